// File: rtl/cache_arbiter.sv
// Two-to-one arbiter between the L1 I-cache and L1 D-cache on the 256-bit line port.
// Ports: I-side read (addr/line/resp), D-side read+write-back (addr/line in/line out/resp),
//        registered downstream request (addr/line/read/write) and adaptor return (line/resp).
// Latency: grant adds one cycle, response adds one cycle; a single transaction in flight.
// Backpressure: clients hold their request until their resp pulse; inputs are ignored
//               outside IDLE, so only one downstream transaction is ever outstanding.
module cache_arbiter #(
  parameter int ARB_MODE = 0  // 0: round-robin on ties, 1: D-cache always wins ties
) (
  input  logic         clk,
  input  logic         rst,
  // I-cache side
  input  logic [31:0]  icache_address_i,
  input  logic         icache_read_i,
  output logic [255:0] icache_line_o,
  output logic         icache_resp_o,
  // D-cache side
  input  logic [31:0]  dcache_address_i,
  input  logic         dcache_read_i,
  input  logic         dcache_write_i,
  input  logic [255:0] dcache_line_i,
  output logic [255:0] dcache_line_o,
  output logic         dcache_resp_o,
  // Downstream (cacheline adaptor) side
  output logic [31:0]  mem_address_o,
  output logic [255:0] mem_line_o,
  output logic         mem_read_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_line_i,
  input  logic         mem_resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;            // client owning the current transaction
  logic          last_grant_q, last_grant_d;  // round-robin history
  logic          kind_q, kind_d;              // 1 = write-back, 0 = read
  logic [31:0]   addr_buf_q, addr_buf_d;
  logic [255:0]  wdata_buf_q, wdata_buf_d;
  logic [255:0]  rdata_buf_q, rdata_buf_d;

  logic          req_i;
  logic          req_d;
  logic          pick;  // winner of the IDLE arbitration

  assign req_i = icache_read_i;
  assign req_d = dcache_read_i | dcache_write_i;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    kind_d       = kind_q;
    addr_buf_d   = addr_buf_q;
    wdata_buf_d  = wdata_buf_q;
    rdata_buf_d  = rdata_buf_q;
    pick         = GNT_I;

    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          pick = (ARB_MODE == 1) ? GNT_D : ~last_grant_q;
        end else begin
          pick = req_d;
        end

        if (req_i || req_d) begin
          state_d      = SERVE;
          grant_d      = pick;
          last_grant_d = pick;
          if (pick == GNT_D) begin
            // A write wins over a simultaneous read on the D side.
            kind_d     = dcache_write_i;
            addr_buf_d = dcache_address_i;
            if (dcache_write_i) begin
              wdata_buf_d = dcache_line_i;
            end
          end else begin
            kind_d     = 1'b0;
            addr_buf_d = icache_address_i;
          end
        end
      end

      SERVE: begin
        // Captured on writes too; the client simply never looks at it.
        if (mem_resp_i) begin
          rdata_buf_d = mem_line_i;
          state_d     = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_I;
      last_grant_q <= GNT_I;
      kind_q       <= 1'b0;
      addr_buf_q   <= '0;
      wdata_buf_q  <= '0;
      rdata_buf_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      kind_q       <= kind_d;
      addr_buf_q   <= addr_buf_d;
      wdata_buf_q  <= wdata_buf_d;
      rdata_buf_q  <= rdata_buf_d;
    end
  end

  // Request strobes drop in RESP so the adaptor, already idle, does not restart.
  assign mem_read_o    = (state_q == SERVE) && !kind_q;
  assign mem_write_o   = (state_q == SERVE) &&  kind_q;
  assign mem_address_o = addr_buf_q;
  assign mem_line_o    = wdata_buf_q;

  assign icache_resp_o = (state_q == RESP) && (grant_q == GNT_I);
  assign dcache_resp_o = (state_q == RESP) && (grant_q == GNT_D);
  assign icache_line_o = rdata_buf_q;
  assign dcache_line_o = rdata_buf_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: two instances (round-robin and D-priority),
// each with a behavioural adaptor of fixed latency; expected transactions are queued
// when requests are driven and checked against every resp pulse.
module tb_cache_arbiter;

  localparam int LAT = 5;  // adaptor cycles from first request cycle to mem_resp

  logic clk;
  logic rst;

  logic [31:0]  i_addr  [2];
  logic         i_rd    [2];
  logic [255:0] i_line  [2];
  logic         i_resp  [2];
  logic [31:0]  d_addr  [2];
  logic         d_rd    [2];
  logic         d_wr    [2];
  logic [255:0] d_wdat  [2];
  logic [255:0] d_line  [2];
  logic         d_resp  [2];
  logic [31:0]  m_addr  [2];
  logic [255:0] m_wline [2];
  logic         m_rd    [2];
  logic         m_wr    [2];
  logic [255:0] m_rline [2];
  logic         m_resp  [2];

  cache_arbiter #(.ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .icache_address_i(i_addr[0]), .icache_read_i(i_rd[0]),
    .icache_line_o(i_line[0]), .icache_resp_o(i_resp[0]),
    .dcache_address_i(d_addr[0]), .dcache_read_i(d_rd[0]), .dcache_write_i(d_wr[0]),
    .dcache_line_i(d_wdat[0]), .dcache_line_o(d_line[0]), .dcache_resp_o(d_resp[0]),
    .mem_address_o(m_addr[0]), .mem_line_o(m_wline[0]), .mem_read_o(m_rd[0]),
    .mem_write_o(m_wr[0]), .mem_line_i(m_rline[0]), .mem_resp_i(m_resp[0])
  );

  cache_arbiter #(.ARB_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .icache_address_i(i_addr[1]), .icache_read_i(i_rd[1]),
    .icache_line_o(i_line[1]), .icache_resp_o(i_resp[1]),
    .dcache_address_i(d_addr[1]), .dcache_read_i(d_rd[1]), .dcache_write_i(d_wr[1]),
    .dcache_line_i(d_wdat[1]), .dcache_line_o(d_line[1]), .dcache_resp_o(d_resp[1]),
    .mem_address_o(m_addr[1]), .mem_line_o(m_wline[1]), .mem_read_o(m_rd[1]),
    .mem_write_o(m_wr[1]), .mem_line_i(m_rline[1]), .mem_resp_i(m_resp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           u;
    bit           d;
    logic [31:0]  addr;
    bit           wr;
    logic [255:0] wdata;
  } exp_t;

  typedef struct {
    int           u;
    bit           ir;
    logic [31:0]  ia;
    bit           dr;
    bit           dw;
    logic [31:0]  da;
    logic [255:0] dd;
    int           hold;  // 0: each client drops on its own resp; N: all held for N pulses
    int           n;     // number of resp pulses expected
    logic [3:0]   ord;   // bit k: client of pulse k (1 = D)
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // adaptor model state, per instance
  int           cnt        [2];
  int           txn_cnt    [2];
  int           exp_txn    [2];
  int           hold_left  [2];
  logic         prev_mresp [2];
  logic [31:0]  seen_addr  [2];
  logic         seen_wr    [2];
  logic [255:0] seen_wdata [2];
  logic         stable     [2];

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_B5A5}};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] expv);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, expv);
    end
  endtask

  task automatic mon(input int u);
    logic ri, rd;
    logic [255:0] ln;
    exp_t e;
    if (rst) begin
      cnt[u] = 0; m_resp[u] = 1'b0; prev_mresp[u] = 1'b0;
      return;
    end
    ri = i_resp[u];
    rd = d_resp[u];
    if (ri || rd || prev_mresp[u])
      chk(((ri | rd) == prev_mresp[u]) && !(ri && rd), "resp_pulse", {ri, rd}, {1'b0, prev_mresp[u]});
    if (ri || rd) begin
      chk(!m_rd[u] && !m_wr[u], "resp_mem_quiet", {m_rd[u], m_wr[u]}, 0);
      chk(sb.size() != 0, "unexpected_resp", sb.size(), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        ln = rd ? d_line[u] : i_line[u];
        chk(e.u == u && e.d == rd, "resp_client", {u[3:0], 3'b0, rd}, {e.u[3:0], 3'b0, e.d});
        chk(ln == line_of(e.addr), "resp_line", ln, line_of(e.addr));
        chk(seen_addr[u] == e.addr, "mem_addr", seen_addr[u], e.addr);
        chk(seen_wr[u] == e.wr, "mem_kind", seen_wr[u], e.wr);
        chk(stable[u], "mem_stable", stable[u], 1);
        if (e.wr) chk(seen_wdata[u] == e.wdata, "mem_wdata", seen_wdata[u], e.wdata);
      end
      if (hold_left[u] > 0) begin
        hold_left[u]--;
        if (hold_left[u] == 0) begin
          i_rd[u] = 1'b0; d_rd[u] = 1'b0; d_wr[u] = 1'b0;
        end
      end else if (rd) begin
        d_rd[u] = 1'b0; d_wr[u] = 1'b0;
      end else begin
        i_rd[u] = 1'b0;
      end
    end
    // adaptor
    if (m_resp[u]) begin
      m_resp[u] = 1'b0;
    end else if (m_rd[u] || m_wr[u]) begin
      cnt[u]++;
      if (cnt[u] == 1) begin
        seen_addr[u] = m_addr[u]; seen_wr[u] = m_wr[u];
        seen_wdata[u] = m_wline[u]; stable[u] = (m_rd[u] != m_wr[u]);
      end else if (m_addr[u] != seen_addr[u] || m_wr[u] != seen_wr[u] ||
                   m_wline[u] != seen_wdata[u] || m_rd[u] == m_wr[u]) begin
        stable[u] = 1'b0;
      end
      if (cnt[u] == LAT) begin
        m_resp[u] = 1'b1;
        m_rline[u] = line_of(m_addr[u]);
        txn_cnt[u]++;
        cnt[u] = 0;
      end
    end
    prev_mresp[u] = m_resp[u];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_done(input int u);
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || i_rd[u] || d_rd[u] || d_wr[u]) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk(cyc < 300, "completion_timeout", cyc, 300);
    repeat (3) @(negedge clk);
    chk(txn_cnt[u] == exp_txn[u], "txn_count", txn_cnt[u], exp_txn[u]);
  endtask

  task automatic apply_row(input vec_t v);
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < v.n; k++) begin
      e.u = v.u; e.d = v.ord[k];
      e.addr = e.d ? v.da : v.ia;
      e.wr = e.d && v.dw;
      e.wdata = v.dd;
      sb.push_back(e);
    end
    exp_txn[v.u] += v.n;
    hold_left[v.u] = v.hold;
    i_addr[v.u] = v.ia; d_addr[v.u] = v.da; d_wdat[v.u] = v.dd;
    i_rd[v.u] = v.ir; d_rd[v.u] = v.dr; d_wr[v.u] = v.dw;
    wait_done(v.u);
  endtask

  task automatic chk_idle_outputs(input int u, input string nm);
    chk(!m_rd[u] && !m_wr[u] && !i_resp[u] && !d_resp[u], nm,
        {m_rd[u], m_wr[u], i_resp[u], d_resp[u]}, 0);
    chk(m_addr[u] == 0 && m_wline[u] == 0, {nm, "_membuf"}, m_wline[u] | m_addr[u], 0);
    chk(i_line[u] == 0 && d_line[u] == 0, {nm, "_lines"}, i_line[u] | d_line[u], 0);
  endtask

  localparam logic [255:0] WD0 = 256'h123456789abcdef0fedcba9876543210123456789abcdef0fedcba9876543210;
  localparam logic [255:0] WD1 = 256'hdeadbeef_00000000_11111111_22222222_33333333_44444444_55555555_66666666;
  localparam logic [255:0] WD2 = 256'h0f0f0f0f_f0f0f0f0_aaaaaaaa_55555555_01234567_89abcdef_cafef00d_0badf00d;

  vec_t tbl [9];
  vec_t fin;
  exp_t eb;

  initial begin
    tbl[0] = '{0, 1'b1, 32'h100,  1'b1, 1'b0, 32'h200,  '0,  4, 4, 4'b0101};
    tbl[1] = '{0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,    '0,  0, 1, 4'b0000};
    tbl[2] = '{0, 1'b0, 32'h0,    1'b0, 1'b1, 32'h2040, WD0, 0, 1, 4'b0001};
    tbl[3] = '{0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3000, WD1, 0, 1, 4'b0001};
    tbl[4] = '{0, 1'b1, 32'h100,  1'b1, 1'b0, 32'h200,  '0,  0, 2, 4'b0010};
    tbl[5] = '{0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,    '0,  2, 2, 4'b0000};
    tbl[6] = '{1, 1'b1, 32'h100,  1'b1, 1'b0, 32'h200,  '0,  3, 3, 4'b0111};
    tbl[7] = '{1, 1'b1, 32'h100,  1'b1, 1'b0, 32'h200,  '0,  0, 2, 4'b0001};
    tbl[8] = '{1, 1'b1, 32'h500,  1'b0, 1'b0, 32'h0,    '0,  0, 1, 4'b0000};
    fin    = '{0, 1'b1, 32'h700,  1'b1, 1'b0, 32'h740,  '0,  0, 2, 4'b0001};

    for (int u = 0; u < 2; u++) begin
      i_addr[u] = '0; i_rd[u] = 1'b0; d_addr[u] = '0; d_rd[u] = 1'b0; d_wr[u] = 1'b0;
      d_wdat[u] = '0; m_rline[u] = '0; m_resp[u] = 1'b0;
      cnt[u] = 0; txn_cnt[u] = 0; exp_txn[u] = 0; hold_left[u] = 0;
      prev_mresp[u] = 1'b0; seen_addr[u] = '0; seen_wr[u] = 1'b0;
      seen_wdata[u] = '0; stable[u] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs(0, "reset0");
    chk_idle_outputs(1, "reset1");
    rst = 1'b0;

    for (int r = 0; r < 9; r++) apply_row(tbl[r]);

    // Write data captured at grant must survive client changes mid-SERVE.
    @(negedge clk);
    eb.u = 0; eb.d = 1'b1; eb.addr = 32'h2080; eb.wr = 1'b1; eb.wdata = WD2;
    sb.push_back(eb);
    exp_txn[0]++;
    hold_left[0] = 0;
    d_addr[0] = 32'h2080; d_wdat[0] = WD2; d_wr[0] = 1'b1;
    @(negedge clk);
    chk(m_wr[0] && !m_rd[0], "write_latency", {m_rd[0], m_wr[0]}, 1);
    chk(m_addr[0] == 32'h2080, "write_addr", m_addr[0], 32'h2080);
    chk(m_wline[0] == WD2, "write_data", m_wline[0], WD2);
    d_wdat[0] = ~WD2; d_addr[0] = 32'h9999_0000;
    @(negedge clk);
    chk(m_wline[0] == WD2, "wdata_hold", m_wline[0], WD2);
    chk(m_addr[0] == 32'h2080, "addr_hold", m_addr[0], 32'h2080);
    wait_done(0);

    // Reset three cycles into a read: transaction abandoned, no resp.
    @(negedge clk);
    i_addr[0] = 32'h4000; i_rd[0] = 1'b1;
    @(negedge clk);
    chk(m_rd[0] && m_addr[0] == 32'h4000, "read_latency", {m_rd[0], m_addr[0]}, {1'b1, 32'h4000});
    repeat (2) @(negedge clk);
    rst = 1'b1; i_rd[0] = 1'b0;
    @(negedge clk);
    chk_idle_outputs(0, "serve_reset");
    rst = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk(txn_cnt[0] == exp_txn[0], "abandoned_txn", txn_cnt[0], exp_txn[0]);

    // After reset the round-robin history is back to I, so D wins the tie.
    apply_row(fin);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
